// File: rtl/ascon_serial_frontend.sv
// Serial front end for the Ascon AEAD core. It loads key, nonce, AD and text over W-bit lanes,
// pulses the core start, and then unloads the result text and tag over W-bit lanes.
module ascon_serial_frontend #(
  parameter int unsigned K       = 128,
  parameter int unsigned L       = 40,
  parameter int unsigned Y       = 96,
  parameter int unsigned W       = 1,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           startxSI,
  input  logic           mode_decxSI,
  input  logic           in_validxSI,
  output logic           in_readyxSO,
  input  logic [W-1:0]   keyxSI,
  input  logic [W-1:0]   noncexSI,
  input  logic [W-1:0]   adxSI,
  input  logic [W-1:0]   textxSI,
  output logic [K-1:0]   core_keyxSO,
  output logic [127:0]   core_noncexSO,
  output logic [L-1:0]   core_adxSO,
  output logic [Y-1:0]   core_textxSO,
  output logic           core_encxSO,
  output logic           core_decxSO,
  input  logic           core_donexSI,
  input  logic [Y-1:0]   core_textxSI,
  input  logic [127:0]   core_tagxSI,
  input  logic           core_authxSI,
  output logic           out_validxSO,
  input  logic           out_readyxSI,
  output logic [W-1:0]   textxSO,
  output logic [W-1:0]   tagxSO,
  output logic           authxSO,
  output logic           busyxSO,
  output logic           donexSO,
  output logic           errxSO
);

  localparam int unsigned NB     = 128;
  localparam int unsigned MaxKn  = (K > NB) ? K : NB;
  localparam int unsigned MaxLy  = (L > Y) ? L : Y;
  localparam int unsigned MaxB   = (MaxKn > MaxLy) ? MaxKn : MaxLy;
  localparam int unsigned LB     = MaxB / W;
  localparam int unsigned UB     = ((Y > NB) ? Y : NB) / W;
  localparam int unsigned CntMax = (LB > UB) ? LB : UB;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned WdW    = $clog2(TIMEOUT);

  localparam logic [CntW-1:0] LastLoad   = CntW'(LB - 1);
  localparam logic [CntW-1:0] LastUnload = CntW'(UB - 1);
  localparam logic [CntW-1:0] KeyBeats   = CntW'(K / W);
  localparam logic [CntW-1:0] NonceBeats = CntW'(NB / W);
  localparam logic [CntW-1:0] AdBeats    = CntW'(L / W);
  localparam logic [CntW-1:0] TextBeats  = CntW'(Y / W);
  localparam logic [WdW-1:0]  WdLast     = WdW'(TIMEOUT - 1);

  if ((K % W) != 0 || (L % W) != 0 || (Y % W) != 0 || (NB % W) != 0) begin : gen_bad_len
    $error("ascon_serial_frontend: K, L, Y and 128 must be multiples of W");
  end
  if (TIMEOUT < 2) begin : gen_bad_timeout
    $error("ascon_serial_frontend: TIMEOUT must be at least 2");
  end

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StWait, StUnload} state_e;

  state_e stateQ, stateD;

  logic [CntW-1:0] beatQ;
  logic [WdW-1:0]  wdQ;
  logic            modeQ, authQ, errQ, doneQ;
  logic [K-1:0]    keyQ;
  logic [NB-1:0]   nonceQ;
  logic [L-1:0]    adQ;
  logic [Y-1:0]    textQ;
  logic [Y-1:0]    resQ;
  logic [NB-1:0]   tagQ;

  logic startAcc, loadBeat, coreDone, timeout, unloadBeat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stateQ <= StIdle;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    startAcc   = 1'b0;
    loadBeat   = 1'b0;
    coreDone   = 1'b0;
    timeout    = 1'b0;
    unloadBeat = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (startxSI) begin
          startAcc = 1'b1;
          stateD   = StLoad;
        end
      end
      StLoad: begin
        if (in_validxSI) begin
          loadBeat = 1'b1;
          if (beatQ == LastLoad) stateD = StStart;
        end
      end
      StStart: stateD = StWait;
      StWait: begin
        // A result arriving on the final watchdog cycle still counts as success.
        if (core_donexSI) begin
          coreDone = 1'b1;
          stateD   = StUnload;
        end else if (wdQ == WdLast) begin
          timeout = 1'b1;
          stateD  = StIdle;
        end
      end
      StUnload: begin
        if (out_readyxSI) begin
          unloadBeat = 1'b1;
          if (beatQ == LastUnload) stateD = StIdle;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beatQ  <= '0;
      wdQ    <= '0;
      modeQ  <= 1'b0;
      authQ  <= 1'b0;
      errQ   <= 1'b0;
      doneQ  <= 1'b0;
      keyQ   <= '0;
      nonceQ <= '0;
      adQ    <= '0;
      textQ  <= '0;
      resQ   <= '0;
      tagQ   <= '0;
    end else begin
      doneQ <= 1'b0;
      wdQ   <= (stateQ == StWait) ? wdQ + WdW'(1) : '0;

      if (startAcc) begin
        modeQ <= mode_decxSI;
        errQ  <= 1'b0;
        authQ <= 1'b0;
        beatQ <= '0;
      end

      // Lanes fill MSB-first by shifting left; a lane stops once its own length is loaded.
      if (loadBeat) begin
        beatQ <= (beatQ == LastLoad) ? '0 : beatQ + CntW'(1);
        if (beatQ < KeyBeats)   keyQ   <= (keyQ << W) | K'(keyxSI);
        if (beatQ < NonceBeats) nonceQ <= (nonceQ << W) | NB'(noncexSI);
        if (beatQ < AdBeats)    adQ    <= (adQ << W) | L'(adxSI);
        if (beatQ < TextBeats)  textQ  <= (textQ << W) | Y'(textxSI);
      end

      if (coreDone) begin
        resQ  <= core_textxSI;
        tagQ  <= core_tagxSI;
        authQ <= modeQ & core_authxSI;
        beatQ <= '0;
      end

      if (timeout) begin
        errQ  <= 1'b1;
        doneQ <= 1'b1;
      end

      // Unload LSB-first by shifting right; exhausted lanes naturally present zeros.
      if (unloadBeat) begin
        resQ <= resQ >> W;
        tagQ <= tagQ >> W;
        if (beatQ == LastUnload) begin
          beatQ <= '0;
          doneQ <= 1'b1;
        end else begin
          beatQ <= beatQ + CntW'(1);
        end
      end
    end
  end

  always_comb begin
    in_readyxSO   = (stateQ == StLoad);
    core_encxSO   = (stateQ == StStart) & ~modeQ;
    core_decxSO   = (stateQ == StStart) & modeQ;
    out_validxSO  = (stateQ == StUnload);
    textxSO       = out_validxSO ? resQ[W-1:0] : '0;
    tagxSO        = out_validxSO ? tagQ[W-1:0] : '0;
    busyxSO       = (stateQ != StIdle);
    donexSO       = doneQ;
    authxSO       = authQ;
    errxSO        = errQ;
    core_keyxSO   = keyQ;
    core_noncexSO = nonceQ;
    core_adxSO    = adQ;
    core_textxSO  = textQ;
  end

endmodule

// File: tb/tb_ascon_serial_frontend.sv
// Bench for ascon_serial_frontend: a transaction table plus random transactions run against
// a simple core model, with the text and tag reassembled from the serial beats.
module tb_ascon_serial_frontend;

  localparam int K  = 128;
  localparam int L  = 40;
  localparam int Y  = 96;
  localparam int W  = 4;
  localparam int TO = 16;
  localparam int LB = 128 / W;
  localparam int UB = 128 / W;

  logic clk = 1'b0, rst = 1'b1;
  logic startxSI = 0, mode_decxSI = 0, in_validxSI = 0, in_readyxSO;
  logic [W-1:0] keyxSI = '0, noncexSI = '0, adxSI = '0, textxSI = '0;
  logic [K-1:0] core_keyxSO;
  logic [127:0] core_noncexSO;
  logic [L-1:0] core_adxSO;
  logic [Y-1:0] core_textxSO;
  logic core_encxSO, core_decxSO, core_donexSI = 0, core_authxSI = 0;
  logic [Y-1:0] core_textxSI = '0;
  logic [127:0] core_tagxSI = '0;
  logic out_validxSO, out_readyxSI = 0;
  logic [W-1:0] textxSO, tagxSO;
  logic authxSO, busyxSO, donexSO, errxSO;

  ascon_serial_frontend #(.K(K), .L(L), .Y(Y), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .startxSI(startxSI), .mode_decxSI(mode_decxSI),
    .in_validxSI(in_validxSI), .in_readyxSO(in_readyxSO), .keyxSI(keyxSI), .noncexSI(noncexSI),
    .adxSI(adxSI), .textxSI(textxSI), .core_keyxSO(core_keyxSO), .core_noncexSO(core_noncexSO),
    .core_adxSO(core_adxSO), .core_textxSO(core_textxSO), .core_encxSO(core_encxSO),
    .core_decxSO(core_decxSO), .core_donexSI(core_donexSI), .core_textxSI(core_textxSI),
    .core_tagxSI(core_tagxSI), .core_authxSI(core_authxSI), .out_validxSO(out_validxSO),
    .out_readyxSI(out_readyxSI), .textxSO(textxSO), .tagxSO(tagxSO), .authxSO(authxSO),
    .busyxSO(busyxSO), .donexSO(donexSO), .errxSO(errxSO)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit           dec;
    logic [127:0] key;
    logic [127:0] nonce;
    logic [39:0]  ad;
    logic [95:0]  txt;
    bit           authIn;
    int           delay;    // core answer delay in cycles after the start pulse, <0 = never
    bit           gaps;
    logic [95:0]  expText;
    logic [127:0] expTag;
    bit           expAuth;
    bit           expErr;
  } txn_t;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Toy core: XOR cipher (an involution, so decrypt inverts encrypt) and a mixed tag.
  function automatic logic [95:0] ctOf(input logic [127:0] k, input logic [127:0] n,
                                      input logic [95:0] x);
    return x ^ k[127:32] ^ n[95:0];
  endfunction

  function automatic logic [127:0] tagOf(input logic [127:0] k, input logic [127:0] n,
                                        input logic [39:0] a, input logic [95:0] x);
    return k ^ {n[63:0], n[127:64]} ^ {a, x[87:0]};
  endfunction

  // Beat b of an MSB-first lane of length n; beyond the lane it drives junk that must be ignored.
  function automatic logic [W-1:0] laneBits(input logic [127:0] v, input int n, input int b);
    if (b < n / W) return W'(v >> (n - (b + 1) * W));
    return W'($urandom);
  endfunction

  task automatic chkAllZero(input string tag);
    chk({tag, "_ctrl"}, {busyxSO, in_readyxSO, out_validxSO, core_encxSO, core_decxSO,
                         donexSO, errxSO, authxSO}, 0);
    chk({tag, "_lanes"}, {textxSO, tagxSO}, 0);
    chk({tag, "_core"}, core_keyxSO | core_noncexSO | 128'(core_adxSO) | 128'(core_textxSO), 0);
  endtask

  task automatic doReset(input string tag);
    #2 rst = 1'b1;
    #1 chkAllZero(tag);
    in_validxSI = 0; out_readyxSI = 0; core_donexSI = 0; startxSI = 0;
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic runTxn(input txn_t t, input int rstLoadBeat, input int rstUnloadBeat,
                        input bit noise);
    int cyc, lb, ub, encCyc, doneCyc, pulses, dlyCnt;
    logic [127:0] gotText, gotTag;
    bit prevStall;
    logic [W-1:0] prevText, prevTag;
    chk("idle_busy", busyxSO, 0);
    chk("idle_ready", in_readyxSO, 0);
    startxSI = 1; mode_decxSI = t.dec;
    step();
    startxSI = 0; mode_decxSI = ~t.dec;
    chk("start_clears_err", errxSO, 0);
    chk("start_clears_auth", authxSO, 0);
    cyc = 1; lb = 0; ub = 0; encCyc = -1; doneCyc = -1; pulses = 0; dlyCnt = -1;
    gotText = '0; gotTag = '0; prevStall = 0; prevText = '0; prevTag = '0;
    while (cyc < 600 && doneCyc < 0) begin
      in_validxSI = 0; out_readyxSI = 0; core_donexSI = 0; startxSI = 0;
      keyxSI = W'($urandom); noncexSI = W'($urandom); adxSI = W'($urandom);
      textxSI = W'($urandom); core_textxSI = {$urandom, $urandom, $urandom};
      core_authxSI = 1'($urandom);
      if (in_readyxSO) begin
        if (rstLoadBeat == lb) begin
          doReset("rst_in_load");
          return;
        end
        if (!t.gaps || $urandom_range(2) != 0) begin
          in_validxSI = 1;
          keyxSI = laneBits(t.key, 128, lb);
          noncexSI = laneBits(t.nonce, 128, lb);
          adxSI = laneBits(128'(t.ad), 40, lb);
          textxSI = laneBits(128'(t.txt), 96, lb);
          lb++;
        end
        if (noise && $urandom_range(3) == 0) core_donexSI = 1;
      end
      if (dlyCnt > 0) begin
        dlyCnt--;
        if (dlyCnt == 0) begin
          core_donexSI = 1;
          core_textxSI = ctOf(t.key, t.nonce, t.txt);
          core_tagxSI = tagOf(t.key, t.nonce, t.ad, t.txt);
          core_authxSI = t.authIn;
          chk("core_inputs_stable", core_keyxSO ^ core_noncexSO, t.key ^ t.nonce);
        end
      end
      if (core_encxSO || core_decxSO) begin
        pulses++;
        if (encCyc < 0) encCyc = cyc;
        chk("start_pulse_kind", {core_encxSO, core_decxSO}, {~t.dec, t.dec});
        chk("core_key", core_keyxSO, t.key);
        chk("core_nonce", core_noncexSO, t.nonce);
        chk("core_ad", 128'(core_adxSO), 128'(t.ad));
        chk("core_text", 128'(core_textxSO), 128'(t.txt));
        dlyCnt = t.delay;
      end
      if (out_validxSO) begin
        if (rstUnloadBeat == ub) begin
          doReset("rst_in_unload");
          return;
        end
        if (prevStall) chk("stall_stable", {textxSO, tagxSO}, {prevText, prevTag});
        prevStall = t.gaps && ($urandom_range(2) == 0);
        out_readyxSI = !prevStall;
        prevText = textxSO; prevTag = tagxSO;
        if (out_readyxSI) begin
          gotText |= 128'(textxSO) << (ub * W);
          gotTag |= 128'(tagxSO) << (ub * W);
          ub++;
        end
      end else begin
        prevStall = 0;
      end
      if (donexSO) doneCyc = cyc;
      if (noise && busyxSO && $urandom_range(4) == 0) startxSI = 1;
      if (doneCyc < 0) begin
        step();
        cyc++;
      end
    end
    in_validxSI = 0; out_readyxSI = 0; core_donexSI = 0; startxSI = 0;
    chk("done_seen", 128'(doneCyc >= 0), 1);
    chk("one_start_pulse", pulses, 1);
    if (!t.gaps) chk("start_latency", encCyc, LB + 1);
    if (t.expErr) begin
      chk("timeout_cycles", doneCyc - encCyc, TO + 1);
      chk("timeout_no_beats", ub, 0);
    end else begin
      chk("unload_beats", ub, UB);
      chk("result_text", gotText, {32'h0, t.expText});
      chk("result_tag", gotTag, t.expTag);
    end
    chk("auth", authxSO, t.expAuth);
    chk("err", errxSO, t.expErr);
    chk("busy_at_done", busyxSO, 0);
    step();
    chk("done_one_cycle", donexSO, 0);
    chk("auth_held", authxSO, t.expAuth);
    chk("err_held", errxSO, t.expErr);
  endtask

  localparam logic [127:0] K1 = 128'h5362006eff0b33bc8bb9950abdb242fc;
  localparam logic [127:0] N1 = 128'h1ccfafbc6dc738283ca9fe21ce0fccaa;
  localparam logic [39:0]  A1 = 40'h4153434f4e;
  localparam logic [95:0]  P1 = 96'h48656c6c6f20576f726c6421;

  txn_t tbl[7];
  txn_t r;

  initial begin
    logic [95:0] c1;
    c1 = ctOf(K1, N1, P1);
    tbl[0] = '{0, K1, N1, A1, P1, 0, 3, 0, c1, tagOf(K1, N1, A1, P1), 0, 0};
    tbl[1] = '{1, K1, N1, A1, c1, 1, 4, 0, P1, tagOf(K1, N1, A1, c1), 1, 0};
    tbl[2] = '{1, K1, N1, A1, c1, 0, 2, 0, P1, tagOf(K1, N1, A1, c1), 0, 0};
    tbl[3] = '{0, K1, N1, A1, P1, 1, 1, 0, c1, tagOf(K1, N1, A1, P1), 0, 0};
    tbl[4] = '{0, K1, N1, A1, P1, 0, 5, 1, c1, tagOf(K1, N1, A1, P1), 0, 0};
    tbl[5] = '{0, K1, N1, A1, P1, 0, -1, 0, '0, '0, 0, 1};
    tbl[6] = '{1, K1, N1, A1, c1, 1, TO, 0, P1, tagOf(K1, N1, A1, c1), 1, 0};

    repeat (2) @(posedge clk);
    #1 chkAllZero("reset_state");
    rst = 0;
    step();

    foreach (tbl[i]) runTxn(tbl[i], -1, -1, 0);

    for (int i = 0; i < 6; i++) begin
      r.dec = 1'($urandom);
      r.key = {$urandom, $urandom, $urandom, $urandom};
      r.nonce = {$urandom, $urandom, $urandom, $urandom};
      r.ad = {8'($urandom), $urandom};
      r.txt = {$urandom, $urandom, $urandom};
      r.authIn = 1'($urandom);
      r.delay = $urandom_range(TO, 1);
      r.gaps = 1;
      r.expText = ctOf(r.key, r.nonce, r.txt);
      r.expTag = tagOf(r.key, r.nonce, r.ad, r.txt);
      r.expAuth = r.dec & r.authIn;
      r.expErr = 0;
      runTxn(r, -1, -1, 1);
    end

    runTxn(tbl[0], 15, -1, 0);
    runTxn(tbl[0], -1, -1, 0);
    runTxn(tbl[1], -1, 10, 0);
    runTxn(tbl[0], -1, -1, 0);
    runTxn(tbl[1], -1, -1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
